set_job_arbiter: RTL

- Shares one SET circle-counting engine between two independent job requesters.
- Arbitrates round-robin and captures the winning job (central, radius, mode).
- Drives the engine's en/central/radius/mode handshake, waits for valid, and routes the candidate count back to the winning requester.
- A watchdog aborts jobs the engine never answers.

---
 rtl/set_job_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/set_job_arbiter.sv
// rtl/set_job_arbiter.sv - round-robin job arbiter in front of one SET circle-counting engine
//
// Shares a single engine between two requesters. A job is captured on the
// arbitration edge, issued with a one-cycle eng_en pulse, and its result is
// routed back on the winner's res_validN strobe. A watchdog aborts jobs the
// engine never answers, returning res_candidate=8'hFF with res_err=1.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req0/central0/radius0/mode0  requester 0 job (held until gnt0)
//   req1/central1/radius1/mode1  requester 1 job (held until gnt1)
//   gnt0, gnt1                   one-cycle job-captured pulses
//   eng_en                       one-cycle engine start pulse
//   eng_central/radius/mode      captured job, held until overwritten
//   eng_busy                     engine cannot accept a job
//   eng_valid, eng_candidate     engine result strobe and count
//   res_valid0, res_valid1       one-cycle result strobes per requester
//   res_candidate, res_err       result count and timeout flag (sticky)
module set_job_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [23:0] central0,
  input  logic [11:0] radius0,
  input  logic [1:0]  mode0,
  output logic        gnt0,
  input  logic        req1,
  input  logic [23:0] central1,
  input  logic [11:0] radius1,
  input  logic [1:0]  mode1,
  output logic        gnt1,
  output logic        eng_en,
  output logic [23:0] eng_central,
  output logic [11:0] eng_radius,
  output logic [1:0]  eng_mode,
  input  logic        eng_busy,
  input  logic        eng_valid,
  input  logic [7:0]  eng_candidate,
  output logic        res_valid0,
  output logic        res_valid1,
  output logic [7:0]  res_candidate,
  output logic        res_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic          win_id;    // requester owning the job in flight
  logic          last_id;   // requester served most recently
  logic [CW-1:0] wd;
  logic          arb_go;
  logic          arb_pick;
  logic          wd_done;

  // On a tie the requester not served last wins; otherwise the lone requester.
  always_comb begin
    arb_go   = (req0 | req1) & ~eng_busy;
    arb_pick = (req0 & req1) ? ~last_id : req1;
    wd_done  = (wd == CW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    eng_en     = 1'b0;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    res_valid0 = 1'b0;
    res_valid1 = 1'b0;
    case (state)
      S_IDLE: begin
        if (arb_go) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        eng_en    = 1'b1;
        gnt0      = ~win_id;
        gnt1      = win_id;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (eng_valid || wd_done) state_nxt = S_RESP;
      end
      S_RESP: begin
        res_valid0 = ~win_id;
        res_valid1 = win_id;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Job capture, pointer, watchdog and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_id        <= 1'b0;
      last_id       <= 1'b1;
      wd            <= '0;
      eng_central   <= '0;
      eng_radius    <= '0;
      eng_mode      <= '0;
      res_candidate <= '0;
      res_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_go) begin
            win_id      <= arb_pick;
            eng_central <= arb_pick ? central1 : central0;
            eng_radius  <= arb_pick ? radius1  : radius0;
            eng_mode    <= arb_pick ? mode1    : mode0;
          end
        end
        S_ISSUE: begin
          last_id <= win_id;
          wd      <= '0;
        end
        S_WAIT: begin
          wd <= wd + CW'(1);
          // A real answer wins over an expiring watchdog on the same edge.
          if (eng_valid) begin
            res_candidate <= eng_candidate;
            res_err       <= 1'b0;
          end else if (wd_done) begin
            res_candidate <= 8'hFF;
            res_err       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
